// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite RAM writer and its dual-port RAM.
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } sprite_wr_state_t;

    localparam int unsigned SCREEN_V_ACTIVE  = 480;
    localparam int unsigned SPRITE_W_DEFAULT = 50;
    localparam int unsigned SPRITE_H_DEFAULT = 50;
    localparam int unsigned DATA_W_DEFAULT   = 4;
    localparam int unsigned ADDR_W_DEFAULT   = 19;

    // Counter width that never collapses to zero bits for tiny sprites.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sprite_dpram.sv
// Sprite RAM: one synchronous write port, one registered read port (read-before-write),
// out-of-range reads return zero. Array contents are not touched by reset.
module sprite_dpram #(
    parameter int unsigned DEPTH  = 2500,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned IDX_W = sprite_pkg::clog2_min1(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              wr_in_range, rd_in_range;

    assign wr_in_range = (wr_addr_i <= ADDR_W'(DEPTH - 1));
    assign rd_in_range = (rd_addr_i <= ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk_i) begin
        if (we_i && wr_in_range) begin
            mem[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
        end
    end

    // Combinational read of the pre-edge array gives read-before-write on a collision.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = mem[rd_addr_i[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sprite_ram_writer.sv
// Streams palette indices into the sprite RAM in raster order for run-time sprite reloads.
// Optional SPRITE_WRITER_VBLANK_GATE_EN restricts transfers to vertical blank (DrawY >= 480).
module sprite_ram_writer
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W = SPRITE_W_DEFAULT,
    parameter int unsigned SPRITE_H = SPRITE_H_DEFAULT,
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [9:0]        DrawY,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] sprite_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned DEPTH = SPRITE_W * SPRITE_H;
    localparam int unsigned XW    = clog2_min1(SPRITE_W);
    localparam int unsigned YW    = clog2_min1(SPRITE_H + 1);

    localparam logic [XW-1:0] X_LAST = XW'(SPRITE_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SPRITE_H - 1);

    sprite_wr_state_t  state_d, state_q;
    logic [XW-1:0]     x_d, x_q;
    logic [YW-1:0]     y_d, y_q;
    logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
    logic              wr_en;
    logic              xfer;
    logic              gate_open;

`ifdef SPRITE_WRITER_VBLANK_GATE_EN
    assign gate_open = (DrawY >= 10'(SCREEN_V_ACTIVE));
`else
    logic unused_draw_y;
    assign gate_open     = 1'b1;
    assign unused_draw_y = ^DrawY;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wr_addr_d = wr_addr_q;
        wr_en     = 1'b0;
        pix_ready = (state_q == LOAD) && gate_open;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        xfer      = pix_valid && pix_ready;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    x_d       = '0;
                    y_d       = '0;
                    wr_addr_d = '0;
                end
            end
            LOAD: begin
                // abort wins over a coincident transfer: that pixel is dropped
                if (abort) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                        if (y_q == Y_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    sprite_dpram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .we_i      (wr_en),
        .wr_addr_i (wr_addr_q),
        .wr_data_i (pix_data),
        .rd_addr_i (read_address),
        .rd_data_o (sprite_data)
    );

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Directed self-checking bench for sprite_ram_writer (default 50x50 sprite, 4-bit pixels).
module tb_sprite_ram_writer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        abort;
    logic [3:0]  pix_data;
    logic        pix_valid;
    logic [9:0]  DrawY;
    logic [18:0] read_address;
    logic        pix_ready;
    logic [3:0]  sprite_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sprite_ram_writer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .abort        (abort),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .DrawY        (DrawY),
        .read_address (read_address),
        .sprite_data  (sprite_data),
        .busy         (busy),
        .done         (done)
    );

    // Present an address, let one edge register it, return the read data.
    task automatic rd(input logic [18:0] a, output logic [3:0] d);
        read_address = a;
        @(negedge Clk);
        d = sprite_data;
    endtask

    // Drives a full-sprite load; pix_data = addr[3:0] ^ xm. Returns timing metrics only.
    task automatic run_load(input logic [3:0] xm, input bit toggle, input bit start_mid,
                            output int rdy_c0, output int first_done, output int ndone,
                            output int nxfer);
        int          addr;
        bit          v;
        bit          acc;
        logic [18:0] a;
        addr       = 0;
        ndone      = 0;
        first_done = -1;
        start      = 1'b1;
        @(negedge Clk);
        start  = 1'b0;
        rdy_c0 = int'(pix_ready);
        for (int c = 0; c < 6000; c++) begin
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (first_done >= 0 && c > first_done + 2) break;
            v     = toggle ? (c % 2 == 0) : 1'b1;
            start = (start_mid && c == 1000);
            a     = 19'(addr);
            if (addr < 2500) begin
                pix_valid = v;
                pix_data  = a[3:0] ^ xm;
            end else begin
                pix_valid = 1'b0;
            end
            acc = v && pix_ready && (addr < 2500);
            @(negedge Clk);
            if (acc) addr++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        nxfer     = addr;
    endtask

    task automatic test_reset();
        Reset        = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        pix_valid    = 1'b0;
        pix_data     = 4'h0;
        DrawY        = 10'd490;
        read_address = 19'd2500;
        repeat (2) @(negedge Clk);
        checks++;
        if ({pix_ready, busy, done, sprite_data} !== 7'b0) begin
            errors++;
            $display("FAIL reset_asserted: got %b required 0000000",
                     {pix_ready, busy, done, sprite_data});
        end
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checks++;
            if ({pix_ready, busy, done, sprite_data} !== 7'b0) begin
                errors++;
                $display("FAIL reset_idle_%0d: got %b required 0000000", i,
                         {pix_ready, busy, done, sprite_data});
            end
        end
    endtask

    task automatic test_back_to_back();
        int rdy_c0, first_done, ndone, nxfer;
        logic [3:0] d;
        // start re-asserted mid-load must be ignored
        run_load(4'h0, 1'b0, 1'b1, rdy_c0, first_done, ndone, nxfer);
        checks++;
        if (rdy_c0 !== 1) begin
            errors++; $display("FAIL b2b_ready_after_start: got %0d required 1", rdy_c0);
        end
        checks++;
        if (first_done !== 2500) begin
            errors++; $display("FAIL b2b_done_cycle: got %0d required 2500", first_done);
        end
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL b2b_done_count: got %0d required 1", ndone);
        end
        checks++;
        if (nxfer !== 2500) begin
            errors++; $display("FAIL b2b_transfers: got %0d required 2500", nxfer);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_after: got busy=%b required 0", busy);
        end
        rd(19'd0, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL b2b_rd0: got %h required 0", d); end
        rd(19'd49, d);
        checks++;
        if (d !== 4'h1) begin errors++; $display("FAIL b2b_rd49: got %h required 1", d); end
        rd(19'd50, d);
        checks++;
        if (d !== 4'h2) begin errors++; $display("FAIL b2b_rd50: got %h required 2", d); end
        rd(19'd2499, d);
        checks++;
        if (d !== 4'h3) begin errors++; $display("FAIL b2b_rd2499: got %h required 3", d); end
    endtask

    task automatic test_valid_toggle();
        int rdy_c0, first_done, ndone, nxfer;
        logic [3:0] d;
        // Inverted data so every location must actually be rewritten.
        run_load(4'hF, 1'b1, 1'b0, rdy_c0, first_done, ndone, nxfer);
        checks++;
        if (first_done !== 4999) begin
            errors++; $display("FAIL tog_done_cycle: got %0d required 4999", first_done);
        end
        checks++;
        if (ndone !== 1) begin
            errors++; $display("FAIL tog_done_count: got %0d required 1", ndone);
        end
        checks++;
        if (nxfer !== 2500) begin
            errors++; $display("FAIL tog_transfers: got %0d required 2500", nxfer);
        end
        rd(19'd0, d);
        checks++;
        if (d !== 4'hF) begin errors++; $display("FAIL tog_rd0: got %h required f", d); end
        rd(19'd49, d);
        checks++;
        if (d !== 4'hE) begin errors++; $display("FAIL tog_rd49: got %h required e", d); end
        rd(19'd50, d);
        checks++;
        if (d !== 4'hD) begin errors++; $display("FAIL tog_rd50: got %h required d", d); end
        rd(19'd2499, d);
        checks++;
        if (d !== 4'hC) begin errors++; $display("FAIL tog_rd2499: got %h required c", d); end
    endtask

    task automatic test_abort();
        int         ndone;
        logic [3:0] d;
        logic [7:0] i8;
        ndone = 0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            i8        = 8'(i);
            pix_valid = 1'b1;
            pix_data  = i8[3:0];
            if (done) ndone++;
            @(negedge Clk);
        end
        pix_valid = 1'b1;
        pix_data  = 4'h4;
        abort     = 1'b1;
        @(negedge Clk);
        abort     = 1'b0;
        pix_valid = 1'b0;
        checks++;
        if ({busy, pix_ready} !== 2'b00) begin
            errors++; $display("FAIL abort_to_idle: got %b required 00", {busy, pix_ready});
        end
        for (int i = 0; i < 3; i++) begin
            if (done) ndone++;
            @(negedge Clk);
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL abort_no_done: got %0d required 0", ndone);
        end
        rd(19'd0, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL abort_rd0: got %h required 0", d); end
        rd(19'd99, d);
        checks++;
        if (d !== 4'h3) begin errors++; $display("FAIL abort_rd99: got %h required 3", d); end
        rd(19'd100, d);
        checks++;
        if (d !== 4'hB) begin errors++; $display("FAIL abort_rd100: got %h required b", d); end
    endtask

    task automatic test_restart_rbw();
        logic [3:0] d;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pix_valid = 1'b1;
            pix_data  = 4'h5;
            @(negedge Clk);
        end
        pix_valid    = 1'b1;
        pix_data     = 4'hA;
        read_address = 19'd7;
        @(negedge Clk);
        pix_valid = 1'b0;
        checks++;
        if (sprite_data !== 4'h7) begin
            errors++; $display("FAIL rbw_old: got %h required 7", sprite_data);
        end
        @(negedge Clk);
        checks++;
        if (sprite_data !== 4'hA) begin
            errors++; $display("FAIL rbw_new: got %h required a", sprite_data);
        end
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        rd(19'd0, d);
        checks++;
        if (d !== 4'h5) begin errors++; $display("FAIL restart_rd0: got %h required 5", d); end
        rd(19'd2500, d);
        checks++;
        if (d !== 4'h0) begin errors++; $display("FAIL rd_out_of_range: got %h required 0", d); end
    endtask

    task automatic test_reset_mid_load();
        int         ndone;
        logic [3:0] d;
        ndone = 0;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1;
            pix_data  = 4'hE;
            @(negedge Clk);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({busy, pix_ready, done, sprite_data} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b required 0000000",
                     {busy, pix_ready, done, sprite_data});
        end
        @(negedge Clk);
        Reset     = 1'b0;
        pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) ndone++;
            @(negedge Clk);
        end
        checks++;
        if (ndone !== 0) begin
            errors++; $display("FAIL reset_mid_quiet: got %0d busy/done cycles required 0", ndone);
        end
        rd(19'd2, d);
        checks++;
        if (d !== 4'hE) begin errors++; $display("FAIL reset_mid_rd2: got %h required e", d); end
        rd(19'd3, d);
        checks++;
        if (d !== 4'h5) begin errors++; $display("FAIL reset_mid_rd3: got %h required 5", d); end
    endtask

`ifdef SPRITE_WRITER_VBLANK_GATE_EN
    task automatic test_vblank();
        logic [3:0] d;
        start = 1'b1;
        @(negedge Clk);
        start     = 1'b0;
        DrawY     = 10'd100;
        pix_valid = 1'b1;
        pix_data  = 4'hC;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({busy, pix_ready} !== 2'b10) begin
                errors++;
                $display("FAIL vblank_closed_%0d: got %b required 10", i, {busy, pix_ready});
            end
            @(negedge Clk);
        end
        DrawY    = 10'd490;
        pix_data = 4'h6;
        #1;
        checks++;
        if (pix_ready !== 1'b1) begin
            errors++; $display("FAIL vblank_open: got %b required 1", pix_ready);
        end
        @(negedge Clk);
        @(negedge Clk);
        pix_valid = 1'b0;
        abort     = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        rd(19'd0, d);
        checks++;
        if (d !== 4'h6) begin errors++; $display("FAIL vblank_rd0: got %h required 6", d); end
        rd(19'd2, d);
        checks++;
        if (d !== 4'hE) begin errors++; $display("FAIL vblank_rd2: got %h required e", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_valid_toggle();
        test_abort();
        test_restart_rbw();
        test_reset_mid_load();
`ifdef SPRITE_WRITER_VBLANK_GATE_EN
        test_vblank();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sprite_ram_writer.md
# sprite_ram_writer

Write-side companion to the per-sprite icon RAMs. Accepts a stream of 4-bit palette indices over a valid/ready handshake and stores them raster-order (row-major, SPRITE_W per row) into an internal dual-port sprite RAM. The renderer reads the same RAM through a registered read port addressed by DrawX/DrawY arithmetic. This lets sprites be reloaded at run time instead of only from `$readmemh` at elaboration.

## Interface
- SPRITE_W, 50, sprite width in pixels
- SPRITE_H, 50, sprite height in pixels
- DATA_W, 4, palette-index width
- ADDR_W, 19, read/write address width
- Clk  input  1  system clock, all logic on posedge
- Reset  input  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- start  input  1  single-cycle request to begin a full-sprite load
- abort  input  1  cancels a load in progress
- pix_data  input  DATA_W  incoming palette index
- pix_valid  input  1  pix_data valid
- pix_ready  output  1  writer can accept pix_data this cycle
- DrawY  input  10  current scan line (used only by the vblank gate)
- read_address  input  ADDR_W  renderer read address
- sprite_data  output  DATA_W  registered read data
- busy  output  1  load in progress
- done  output  1  one-cycle pulse after last pixel written

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: pix_ready=0, busy=0. start=1 -> LOAD; x, y, wr_addr cleared to 0.
- LOAD: busy=1, pix_ready=1 (subject to Configuration gate). Transfer occurs on a cycle with pix_valid && pix_ready: mem[wr_addr] <= pix_data, wr_addr += 1, x += 1; when x == SPRITE_W-1, x wraps to 0 and y += 1.
- wr_addr is maintained incrementally. It equals y*SPRITE_W + x at all times; no multiplier.
- Transfer at x == SPRITE_W-1 and y == SPRITE_H-1 -> DONE.
- DONE: lasts one cycle, done=1, busy=1, pix_ready=0, then IDLE.
- start while in LOAD or DONE is ignored.
- abort in LOAD -> IDLE next cycle, with no done pulse. Pixels already written are retained. abort has priority over a same-cycle transfer: that pixel is not written.
- abort in IDLE or DONE is ignored.
- Read port: sprite_data <= mem[read_address] each cycle.
  - read_address > SPRITE_W*SPRITE_H-1 yields 0.
  - Same-address read and write in one cycle returns the old data (read-before-write).
- RAM contents are not cleared by Reset.

## Timing
- Reset values: state IDLE, x=y=wr_addr=0, pix_ready=0, busy=0, done=0, sprite_data=0.
- pix_ready and busy are decoded from registered state; pix_ready additionally depends combinationally on DrawY when gated.
- start sampled at edge n -> pix_ready=1 from cycle n+1.
- Write at edge k, read of the same address presented in cycle k+1 -> new data on sprite_data after edge k+2.
- Read latency is 1 cycle.
- Minimum load time: SPRITE_W*SPRITE_H transfers + 1 DONE cycle. With pix_valid held high, done is high exactly 2500 cycles after the first pix_ready cycle for the default parameters.
- Reset asserted mid-LOAD -> IDLE immediately. Partially written RAM is retained, and no done pulse is produced.

## Configuration
- SPRITE_WRITER_VBLANK_GATE_EN defined: pix_ready in LOAD is 1 only while DrawY >= 480 (vertical blank). This prevents tearing of the sprite being drawn. State and counters hold while the gate is closed.
- Not defined: pix_ready=1 throughout LOAD regardless of DrawY, and the DrawY port is unused.

## Structure
- Shared package sprite_pkg:
  - state enum sprite_wr_state_t {IDLE, LOAD, DONE}
  - constants SCREEN_V_ACTIVE=480, default SPRITE_W/H, DATA_W
- One sub-module, sprite_dpram: one synchronous write port, one registered read port, read-before-write, out-of-range read returns 0.
- The FSM, counters and gate live in sprite_ram_writer.

## Test plan
- Reset, then idle 5 cycles -> pix_ready=0, busy=0, done=0, sprite_data=0.
- start, then 2500 back-to-back pixels with pix_data = addr[3:0] -> done pulses once; reading addresses 0, 49, 50, 2499 returns 0x0, 0x1, 0x2, 0x3.
- Same load with pix_valid toggling every other cycle -> identical RAM contents; done occurs after 2500 accepted transfers only.
- abort after 100 transfers, coincident with a valid pixel -> addresses 0..99 written, address 100 unchanged, no done; a subsequent start restarts at address 0.
- Write 0xA to address 7 while read_address=7 in the same cycle -> old value returned; value 0xA appears one read later. read_address=2500 -> 0.
- With SPRITE_WRITER_VBLANK_GATE_EN defined: DrawY=100 -> pix_ready=0 during LOAD and counters frozen; DrawY=490 -> transfers proceed.
